// File: rtl/mips_pkg.sv
// Shared MIPS opcode/function constants and the write-back queue entry type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_decode.sv
// Decides whether a retired instruction writes the register file, and where/what.
module wb_decode
  import mips_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd15
) (
  input  logic [31:0] instr,
  input  logic [31:0] alu,
  input  logic [31:0] mem,
  input  logic [31:0] pc,
  output logic        has_write,
  output logic [4:0]  dest,
  output logic [31:0] data
);

  logic [5:0] op;
  logic [5:0] func;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign func        = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // Opcode-driven destination/data selection; writes to r0 are dropped.
  always_comb begin
    has_write = 1'b0;
    dest      = 5'd0;
    data      = alu;
    case (op)
      OP_RTYPE: begin
        if (func != FN_JR) begin
          has_write = 1'b1;
          dest      = instr[15:11];
        end
      end
      OP_BEQ, OP_BNE, OP_SW, OP_J: begin
        has_write = 1'b0;
      end
      OP_JAL: begin
        has_write = 1'b1;
        dest      = LINK_REG;
        data      = pc;
      end
      OP_LW: begin
        has_write = 1'b1;
        dest      = instr[20:16];
        data      = mem;
      end
      default: begin
        has_write = 1'b1;
        dest      = instr[20:16];
      end
    endcase
    if (dest == 5'd0) begin
      has_write = 1'b0;
    end
  end

endmodule

// File: rtl/wb_write_sequencer.sv
// Queues decoded register writes and retires them in order through one write port.
module wb_write_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINK_REG = 15
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_alu,
  input  logic [31:0]              in_mem,
  input  logic [31:0]              in_pc,
  output logic                     WE,
  output logic [4:0]               WA,
  output logic [31:0]              WD,
  input  logic                     wr_ready,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_n [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_n, wr_n;
  logic [CW-1:0]     count_n;
  logic [31:0]       busy_n;
  wb_entry_t         head_n;
  logic              dec_write;
  logic [4:0]        dec_dest;
  logic [31:0]       dec_data;
  logic              push, pop;

  wb_decode #(.LINK_REG(5'(LINK_REG))) u_decode (
    .instr     (in_instr),
    .alu       (in_alu),
    .mem       (in_mem),
    .pc        (in_pc),
    .has_write (dec_write),
    .dest      (dec_dest),
    .data      (dec_data)
  );

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && dec_write;
  assign pop      = WE && wr_ready;

  // Next FIFO state, next head entry and next busy mask after this cycle's push/pop.
  always_comb begin
    mem_n = mem_q;
    if (push) begin
      mem_n[wr_ptr] = '{dest: dec_dest, data: dec_data};
    end
    rd_n    = rd_ptr + PW'(pop);
    wr_n    = wr_ptr + PW'(push);
    count_n = count + CW'(push) - CW'(pop);
    head_n  = mem_n[rd_n];
    busy_n  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_n) begin
        busy_n[mem_n[PW'(rd_n + PW'(k))].dest] = 1'b1;
      end
    end
    busy_n[0] = 1'b0;
  end

  // State and registered write-port outputs; WA/WD hold when the queue drains.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      busy   <= '0;
      WE     <= 1'b0;
      WA     <= 5'd0;
      WD     <= 32'd0;
    end else begin
      mem_q  <= mem_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count  <= count_n;
      busy   <= busy_n;
      WE     <= (count_n != '0);
      if (count_n != '0) begin
        WA <= head_n.dest;
        WD <= head_n.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer with a queue-based reference model.
module tb_wb_write_sequencer;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_alu, in_mem, in_pc;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        wr_ready;
  logic [31:0] busy;
  logic [2:0]  count;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  wb_entry_t q[$];

  always #5 clk = ~clk;

  wb_write_sequencer #(.DEPTH(DEPTH), .LINK_REG(15)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc),
    .WE(we), .WA(wa), .WD(wd), .wr_ready(wr_ready), .busy(busy), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Reference decode: returns 1 when the instruction writes, with dest/data.
  function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] alu,
                                    input logic [31:0] mm, input logic [31:0] pc,
                                    output wb_entry_t e);
    logic [5:0] op;
    op = ins[31:26];
    e.data = alu;
    e.dest = ins[20:16];
    if (op == 6'b000000) begin
      if (ins[5:0] == 6'b001000) return 1'b0;
      e.dest = ins[15:11];
    end else if (op == 6'b000100 || op == 6'b000101 || op == 6'b101011 || op == 6'b000010) begin
      return 1'b0;
    end else if (op == 6'b000011) begin
      e.dest = 5'd15;
      e.data = pc;
    end else if (op == 6'b100011) begin
      e.data = mm;
    end
    return e.dest != 5'd0;
  endfunction

  // Model: pop-then-push on each rising edge, queue cleared by reset.
  always @(posedge clk) begin
    wb_entry_t e;
    bit        wr;
    bit        can_take;
    if (!rst_n) begin
      q.delete();
    end else begin
      can_take = (q.size() < DEPTH);
      wr = ref_decode(in_instr, in_alu, in_mem, in_pc, e);
      if (q.size() > 0 && wr_ready) void'(q.pop_front());
      if (in_valid && can_take && wr) q.push_back(e);
    end
  end

  // Compare DUT against the model every cycle once out of reset.
  always @(negedge clk) begin
    logic [31:0] eb;
    if (chk_en) begin
      eb = '0;
      foreach (q[i]) eb[q[i].dest] = 1'b1;
      chk("we", 32'(we), 32'(q.size() > 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("busy", busy, eb);
      if (q.size() > 0) begin
        chk("wa", 32'(wa), 32'(q[0].dest));
        chk("wd", wd, q[0].data);
      end
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] mm, input logic [31:0] pc, input logic wrr);
    in_valid = v; in_instr = ins; in_alu = alu; in_mem = mm; in_pc = pc; wr_ready = wrr;
    @(negedge clk);
  endtask

  task automatic idle(input logic wrr);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, wrr);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_alu = '0; in_mem = '0; in_pc = '0; wr_ready = 1'b0;
    @(negedge clk);
    idle(1'b0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: R-type add $8 <- 5
    drive(1'b1, 32'h012A4020, 32'h5, 32'h0, 32'h0, 1'b1);
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_wa", 32'(wa), 32'd8);
    chk("t1_wd", wd, 32'h5);
    chk("t1_busy", busy, 32'h0000_0100);
    idle(1'b1);
    chk("t1_busy_clr", busy, 32'd0);

    // 2: lw then jal back-to-back
    drive(1'b1, 32'h8D090004, 32'h0, 32'hDEAD, 32'h0, 1'b1);
    chk("t2_wa_lw", 32'(wa), 32'd9);
    chk("t2_wd_lw", wd, 32'hDEAD);
    drive(1'b1, 32'h0C000010, 32'h0, 32'h0, 32'h40, 1'b1);
    chk("t2_wa_jal", 32'(wa), 32'd15);
    chk("t2_wd_jal", wd, 32'h40);
    idle(1'b1);

    // 3: sw, beq, j, jr, addi rt=0: no writes
    drive(1'b1, 32'hAD090004, 32'h1, 32'h2, 32'h3, 1'b1);
    drive(1'b1, 32'h11090003, 32'h1, 32'h2, 32'h3, 1'b1);
    drive(1'b1, 32'h08000010, 32'h1, 32'h2, 32'h3, 1'b1);
    drive(1'b1, 32'h03E00008, 32'h1, 32'h2, 32'h3, 1'b1);
    drive(1'b1, 32'h21200005, 32'h1, 32'h2, 32'h3, 1'b1);
    chk("t3_we", 32'(we), 32'd0);
    chk("t3_count", 32'(count), 32'd0);

    // 4: fill with wr_ready low, 5th held, then drain in order
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 32'h2000_0000 | (32'(i) << 16), 32'(i) * 32'h10, 32'h0, 32'h0, 1'b0);
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    chk("t4_busy_full", busy, 32'h0000_001E);
    drive(1'b1, 32'h20050000, 32'h50, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h20050000, 32'h50, 32'h0, 32'h0, 1'b1);
    chk("t4_count_pop1", 32'(count), 32'd3);
    chk("t4_in_ready_pop1", 32'(in_ready), 32'd1);
    chk("t4_wa_pop1", 32'(wa), 32'd2);
    drive(1'b1, 32'h20050000, 32'h50, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t4_drained", 32'(count), 32'd0);

    // 5: two writes to $3 keep busy[3] until second pop; reset discards queue
    drive(1'b1, 32'h20030000, 32'h11, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h20030000, 32'h22, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h20070000, 32'h77, 32'h0, 32'h0, 1'b0);
    idle(1'b1);
    chk("t5_busy3_first", busy, 32'h0000_0088);
    idle(1'b1);
    chk("t5_busy3_second", busy, 32'h0000_0080);
    chk("t5_wa_second", 32'(wa), 32'd7);
    idle(1'b1);
    drive(1'b1, 32'h20040000, 32'h1, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h20050000, 32'h2, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h20060000, 32'h3, 32'h0, 32'h0, 1'b0);
    chk("t5_count3", 32'(count), 32'd3);
    rst_n = 1'b0;
    idle(1'b1);
    chk("t5_rst_we", 32'(we), 32'd0);
    chk("t5_rst_busy", busy, 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
